fft_mod_arbiter: RTL and testbench
==================================

# fft_mod_arbiter

Frame-level round-robin arbiter that lets two FFT output streams share the single magnitude datapath (|X|² then square root). It grants one channel a whole frame at a time and forwards that channel's real/imag beats to the datapath. A delay line tags the datapath's result stream with channel, start-of-frame and end-of-frame, aligned to the datapath latency. It sits between the two FFT cores and the magnitude block, upstream of the spectrum buffers.

## Interface
Parameters:
- DW, 16, width of real/imag samples (two's complement)
- FRAME_LEN, 256, beats per frame
- PIPE_LAT, 19, cycles from mod_valid to the matching datapath result
- GAP_CYC, 2, idle cycles forced between frames

Ports:
- clk_50m  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ch0_real, ch0_imag  in  DW  channel 0 sample
- ch0_sop, ch0_eop, ch0_valid  in  1  channel 0 framing and valid
- ch0_ready  out  1  channel 0 beat accepted when valid&ready
- ch1_real, ch1_imag, ch1_sop, ch1_eop, ch1_valid, ch1_ready  same as channel 0, for channel 1
- mod_real, mod_imag  out  DW  registered beat to the datapath
- mod_valid  out  1  beat valid to the datapath
- res_valid, res_sop, res_eop  out  1  result tags, aligned to the datapath output
- res_ch  out  1  channel that owns the result beat
- len_err  out  1  one-cycle pulse on a frame length violation
- drop_err  out  1  one-cycle pulse when a stray beat is discarded

## Operation
States:
- IDLE: no grant. chX_ready is 1 only for a channel presenting valid&!sop; that beat is discarded and drop_err pulses. Request for channel X is chX_valid&chX_sop.
- GRANT0 / GRANT1: the granted channel's ready is 1 and the other channel's ready is 0.
- GAP: both ready = 0 for GAP_CYC cycles, then return to IDLE.

Arbitration:
- Only one channel requests: grant it.
- Both channels request: grant the channel that is not `last`.
- `last` is updated on every grant. It resets to 1, so channel 0 wins the first tie.

Beat handling:
- Each transfer (valid&ready in GRANT) registers the beat into mod_real/mod_imag with mod_valid = 1.
- No-transfer cycles drive mod_valid = 0 and hold mod_real/mod_imag.
- Valid gaps inside a frame are allowed.
- A 9-bit beat counter clears on grant and increments on each transfer.

Frame end:
- Transfer of eop at count == FRAME_LEN-1: normal end, go to GAP.
- Eop at any other count: end the frame, pulse len_err, go to GAP.
- Transfer at count == FRAME_LEN-1 without eop: force the frame end, set the tag eop = 1, pulse len_err, go to GAP.
- A sop inside a frame is ignored and forwarded as an ordinary beat. No error is raised.

Tagging:
- A PIPE_LAT-deep shift register carries {valid, sop, eop, ch} alongside mod_valid.
- The tag sop is the first beat of the grant. The tag eop is the end beat (natural or forced).

## Timing
- Reset value of every output is 0, including ready, mod_*, res_*, len_err and drop_err. Reset also clears the state to IDLE, the counter, the delay line and the gap counter, and sets last = 1.
- Reset asserted mid-frame abandons the frame. No res_eop is produced for it.
- Request seen in IDLE at cycle N: state is GRANTx and ready = 1 at cycle N+1. ready is a registered state decode.
- Transfer at cycle T: mod_valid = 1 at T+1. The matching res_valid/res_sop/res_eop/res_ch appear at T+1+PIPE_LAT.
- After the end beat at cycle E: GAP covers E+1 … E+GAP_CYC. IDLE is reached at E+GAP_CYC+1, and the earliest next grant is at E+GAP_CYC+2.
- len_err is asserted the cycle after the offending transfer.
- drop_err is asserted the cycle after the discarded beat.
- The beat counter cannot wrap, because the frame always ends at FRAME_LEN-1.

## Test plan
- Single ch0 frame, 256 contiguous beats → ch0_ready from cycle N+1. Expect 256 mod_valid cycles, res_sop/res_eop 20 cycles after the first/last transfer, res_ch = 0, and no errors.
- ch0 and ch1 raise sop in the same cycle from reset → ch0 is granted first. ch1 is granted exactly 4 cycles after ch0's eop transfer. res_ch shows 256 zeros, then 256 ones.
- Both channels request continuously for 4 frames → grants alternate 0,1,0,1 and `last` toggles on each grant.
- ch1 eop at beat 100 → frame ends after 101 beats, len_err pulses once, and res_eop is on beat 101. In a separate run, no eop by beat 255 → forced end, res_eop on beat 256, and len_err pulses.
- ch0 asserts valid without sop while IDLE → ch0_ready = 1 and drop_err pulses once. mod_valid stays 0.
- Source valid toggling 1/0 mid-frame, then rst asserted at beat 128 → mod_valid follows transfers only. After reset all outputs are 0 and the next sop is granted normally.

Source files
------------

// File: rtl/fft_mod_arbiter.sv
// Frame-level round-robin arbiter feeding two FFT streams into one magnitude datapath,
// with a delay line that tags datapath results with channel and frame boundaries.
module fft_mod_arbiter #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 256,
    parameter int PIPE_LAT  = 19,
    parameter int GAP_CYC   = 2
) (
    input  logic          clk_50m,
    input  logic          rst,
    input  logic [DW-1:0] ch0_real,
    input  logic [DW-1:0] ch0_imag,
    input  logic          ch0_sop,
    input  logic          ch0_eop,
    input  logic          ch0_valid,
    output logic          ch0_ready,
    input  logic [DW-1:0] ch1_real,
    input  logic [DW-1:0] ch1_imag,
    input  logic          ch1_sop,
    input  logic          ch1_eop,
    input  logic          ch1_valid,
    output logic          ch1_ready,
    output logic [DW-1:0] mod_real,
    output logic [DW-1:0] mod_imag,
    output logic          mod_valid,
    output logic          res_valid,
    output logic          res_sop,
    output logic          res_eop,
    output logic          res_ch,
    output logic          len_err,
    output logic          drop_err
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

    localparam logic [8:0] LAST_CNT = 9'(FRAME_LEN - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    state_t        state, state_nxt;
    logic          last, first;
    logic          tag_sop, tag_eop, tag_ch;
    logic [8:0]    cnt;
    logic [7:0]    gap_cnt;
    logic          req0, req1, xfer, sel_ch, sel_eop, at_last, end_beat, len_bad, drop;
    logic [DW-1:0] sel_real, sel_imag;
    logic [3:0]    dly [PIPE_LAT];

    assign req0     = ch0_valid & ch0_sop;
    assign req1     = ch1_valid & ch1_sop;
    assign sel_ch   = (state == GRANT1);
    assign sel_real = sel_ch ? ch1_real : ch0_real;
    assign sel_imag = sel_ch ? ch1_imag : ch0_imag;
    assign sel_eop  = sel_ch ? ch1_eop  : ch0_eop;
    assign at_last  = (cnt == LAST_CNT);
    assign end_beat = sel_eop | at_last;
    // Only eop landing exactly on the last count is a clean end; any other end is an error.
    assign len_bad  = sel_eop ^ at_last;
    assign drop     = (state == IDLE) & ((ch0_valid & ~ch0_sop) | (ch1_valid & ~ch1_sop));

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ch0_ready = 1'b0;
        ch1_ready = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                ch0_ready = ch0_valid & ~ch0_sop;
                ch1_ready = ch1_valid & ~ch1_sop;
                if (req0 && (!req1 || last)) state_nxt = GRANT0;
                else if (req1)               state_nxt = GRANT1;
            end
            GRANT0: begin
                ch0_ready = 1'b1;
                xfer      = ch0_valid;
                if (xfer && end_beat) state_nxt = GAP;
            end
            GRANT1: begin
                ch1_ready = 1'b1;
                xfer      = ch1_valid;
                if (xfer && end_beat) state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            mod_real  <= '0;
            mod_imag  <= '0;
            mod_valid <= 1'b0;
            tag_sop   <= 1'b0;
            tag_eop   <= 1'b0;
            tag_ch    <= 1'b0;
            len_err   <= 1'b0;
            drop_err  <= 1'b0;
            cnt       <= '0;
            gap_cnt   <= '0;
            first     <= 1'b0;
            last      <= 1'b1;
        end else begin
            mod_valid <= xfer;
            tag_sop   <= xfer & first;
            tag_eop   <= xfer & end_beat;
            len_err   <= xfer & len_bad;
            drop_err  <= drop;
            if (xfer) begin
                mod_real <= sel_real;
                mod_imag <= sel_imag;
                tag_ch   <= sel_ch;
                cnt      <= cnt + 9'd1;
                first    <= 1'b0;
            end
            if (state == IDLE && state_nxt != IDLE) begin
                last  <= (state_nxt == GRANT1);
                cnt   <= '0;
                first <= 1'b1;
            end
            if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
            else              gap_cnt <= '0;
        end
    end

    // Tags travel alongside mod_valid so they emerge with the datapath result.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {mod_valid, tag_sop, tag_eop, tag_ch};
            for (int unsigned i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign {res_valid, res_sop, res_eop, res_ch} = dly[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_mod_arbiter.sv
// Scoreboard bench for fft_mod_arbiter: drivers push expected beats/tags on acceptance,
// a negedge monitor pops and compares mod_* and res_* outputs.
module tb_fft_mod_arbiter;
    localparam int DW = 16;
    localparam int FL = 256;
    localparam int PL = 19;
    localparam int GC = 2;

    logic          clk_50m = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] ch0_real = '0, ch0_imag = '0, ch1_real = '0, ch1_imag = '0;
    logic          ch0_sop = 1'b0, ch0_eop = 1'b0, ch0_valid = 1'b0;
    logic          ch1_sop = 1'b0, ch1_eop = 1'b0, ch1_valid = 1'b0;
    logic          ch0_ready, ch1_ready;
    logic [DW-1:0] mod_real, mod_imag;
    logic          mod_valid, res_valid, res_sop, res_eop, res_ch, len_err, drop_err;

    fft_mod_arbiter #(.DW(DW), .FRAME_LEN(FL), .PIPE_LAT(PL), .GAP_CYC(GC)) dut (
        .clk_50m(clk_50m), .rst(rst),
        .ch0_real(ch0_real), .ch0_imag(ch0_imag), .ch0_sop(ch0_sop), .ch0_eop(ch0_eop),
        .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
        .ch1_real(ch1_real), .ch1_imag(ch1_imag), .ch1_sop(ch1_sop), .ch1_eop(ch1_eop),
        .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
        .mod_real(mod_real), .mod_imag(mod_imag), .mod_valid(mod_valid),
        .res_valid(res_valid), .res_sop(res_sop), .res_eop(res_eop), .res_ch(res_ch),
        .len_err(len_err), .drop_err(drop_err)
    );

    always #10 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    typedef struct {
        int            ch;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        bit            sop;
        bit            eop;
        bit            lerr;
        int            t;
    } beat_t;

    beat_t mod_q[$];
    beat_t res_q[$];
    int    owner_log[$];
    int    vectors = 0, miscompares = 0;
    int    exp_len = 0, got_len = 0, exp_drop = 0, got_drop = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int ch, input bit v, input bit s, input bit e,
                         input logic [DW-1:0] re, input logic [DW-1:0] im);
        if (ch == 0) begin
            ch0_valid = v; ch0_sop = s; ch0_eop = e; ch0_real = re; ch0_imag = im;
        end else begin
            ch1_valid = v; ch1_sop = s; ch1_eop = e; ch1_real = re; ch1_imag = im;
        end
    endtask

    // Frame end per the rules: eop by beat FRAME_LEN ends it, otherwise forced at FRAME_LEN;
    // anything other than eop exactly on the FRAME_LEN-th beat is a length error.
    task automatic send_frame(input int ch, input int nbeats, input bit has_eop, input int gap_pct,
                              input int abort_at, output int first_t, output int end_t);
        int            end_idx, wait_cnt;
        bit            err, s, e, acc;
        logic [DW-1:0] re, im;
        beat_t         b;
        if (has_eop && nbeats <= FL) begin
            end_idx = nbeats - 1;
            err     = (nbeats != FL);
        end else begin
            end_idx = FL - 1;
            err     = 1'b1;
        end
        first_t = -1;
        end_t   = -1;
        for (int i = 0; i <= end_idx; i++) begin
            if (i > 0 && $urandom_range(99) < gap_pct) begin
                drive(ch, 1'b0, 1'b0, 1'b0, '0, '0);
                @(posedge clk_50m); #1;
            end
            re = DW'($urandom);
            im = DW'($urandom);
            s  = (i == 0) || ($urandom_range(15) == 0);
            e  = has_eop && (i == nbeats - 1);
            drive(ch, 1'b1, s, e, re, im);
            wait_cnt = 0;
            acc      = 1'b0;
            while (!acc) begin
                @(negedge clk_50m);
                acc = (ch == 0) ? ch0_ready : ch1_ready;
                if (!acc) begin
                    wait_cnt++;
                    if (wait_cnt > 3000) begin
                        check("accept_timeout", acc, 1);
                        drive(ch, 1'b0, 1'b0, 1'b0, '0, '0);
                        return;
                    end
                end
            end
            b.ch = ch; b.re = re; b.im = im;
            b.sop = (i == 0); b.eop = (i == end_idx); b.lerr = (i == end_idx) && err;
            b.t = cyc + 1;
            mod_q.push_back(b);
            res_q.push_back(b);
            if (i == 0)       first_t = b.t;
            if (i == end_idx) end_t   = b.t;
            @(posedge clk_50m); #1;
            if (i == abort_at) return;
        end
        if (err) exp_len++;
        drive(ch, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input bit now);
        if (!now) begin
            @(posedge clk_50m); #1;
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        mod_q.delete();
        res_q.delete();
        repeat (2) @(posedge clk_50m);
        @(negedge clk_50m);
        check("reset_outputs", {ch0_ready, ch1_ready, mod_real, mod_imag, mod_valid, res_valid,
                                res_sop, res_eop, res_ch, len_err, drop_err}, 0);
        @(posedge clk_50m); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((mod_q.size() != 0 || res_q.size() != 0) && n < 400) begin
            @(posedge clk_50m);
            n++;
        end
        check("drain_queues", mod_q.size() + res_q.size(), 0);
        repeat (4) @(posedge clk_50m);
        #1;
    endtask

    beat_t mon_b;
    always @(negedge clk_50m) begin
        if (!rst) begin
            if (mod_valid) begin
                check("mod_pending", mod_q.size() > 0, 1);
                if (mod_q.size() > 0) begin
                    mon_b = mod_q.pop_front();
                    check("mod_data", {mod_real, mod_imag}, {mon_b.re, mon_b.im});
                    check("mod_time", cyc, mon_b.t);
                    check("len_err", len_err, mon_b.lerr);
                    if (mon_b.sop) owner_log.push_back(mon_b.ch);
                end
            end else begin
                check("len_err_idle", len_err, 0);
            end
            if (res_valid) begin
                check("res_pending", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    mon_b = res_q.pop_front();
                    check("res_tags", {res_ch, res_sop, res_eop}, {1'(mon_b.ch), mon_b.sop, mon_b.eop});
                    check("res_time", cyc, mon_b.t + PL);
                end
            end
            if (len_err)  got_len++;
            if (drop_err) got_drop++;
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int p, base, base_len, f0, e0, f1, e1, f2, e2, f3, e3;
    initial begin
        do_reset(1'b0);

        // Single ch0 frame, contiguous
        @(posedge clk_50m); #1;
        p = cyc;
        send_frame(0, FL, 1'b1, 0, -1, f0, e0);
        check("t1_first_xfer", f0, p + 2);
        check("t1_frame_span", e0 - f0, FL - 1);
        drain();

        // Simultaneous sop after reset: ch0 first, ch1 four cycles after ch0 eop
        do_reset(1'b0);
        base = owner_log.size();
        fork
            send_frame(0, FL, 1'b1, 0, -1, f0, e0);
            send_frame(1, FL, 1'b1, 0, -1, f1, e1);
        join
        drain();
        check("t2_ch1_grant_delay", f1, e0 + 4);
        check("t2_frames", owner_log.size() - base, 2);
        if (owner_log.size() - base == 2) begin
            check("t2_owner0", owner_log[base], 0);
            check("t2_owner1", owner_log[base + 1], 1);
        end

        // Continuous requests on both channels: grants alternate 0,1,0,1
        base = owner_log.size();
        fork
            begin
                send_frame(0, FL, 1'b1, 0, -1, f0, e0);
                send_frame(0, FL, 1'b1, 0, -1, f2, e2);
            end
            begin
                send_frame(1, FL, 1'b1, 0, -1, f1, e1);
                send_frame(1, FL, 1'b1, 0, -1, f3, e3);
            end
        join
        drain();
        check("t3_frames", owner_log.size() - base, 4);
        if (owner_log.size() - base == 4)
            for (int k = 0; k < 4; k++) check("t3_grant_order", owner_log[base + k], k % 2);

        // Short frame (eop at beat 100) and missing eop (forced end)
        base_len = got_len;
        send_frame(1, 101, 1'b1, 0, -1, f1, e1);
        drain();
        check("t4_short_len_err", got_len - base_len, 1);
        check("t4_short_span", e1 - f1, 100);
        base_len = got_len;
        send_frame(0, FL + 44, 1'b0, 0, -1, f0, e0);
        drain();
        check("t4_forced_len_err", got_len - base_len, 1);
        check("t4_forced_span", e0 - f0, FL - 1);

        // Stray beat while idle
        drive(0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678);
        @(negedge clk_50m);
        check("t5_stray_ready", ch0_ready, 1);
        exp_drop++;
        @(posedge clk_50m); #1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk_50m);
        check("t5_drop_err", drop_err, 1);
        drain();

        // Gappy frame abandoned by reset at beat 128, then a normal frame
        send_frame(0, FL, 1'b1, 50, 127, f0, e0);
        do_reset(1'b1);
        @(posedge clk_50m); #1;
        p = cyc;
        send_frame(0, FL, 1'b1, 0, -1, f0, e0);
        check("t6_regrant", f0, p + 2);
        drain();

        // Randomized traffic on both channels
        for (int it = 0; it < 8; it++) begin
            fork
                begin
                    int sel, n, d;
                    sel = int'($urandom_range(3));
                    n = (sel == 0) ? FL : (sel == 1) ? int'($urandom_range(1, FL - 1)) : FL + 10;
                    d = int'($urandom_range(6));
                    repeat (d) begin @(posedge clk_50m); #1; end
                    send_frame(0, n, sel != 2, int'($urandom_range(40)), -1, f0, e0);
                end
                begin
                    int sel, n, d;
                    sel = int'($urandom_range(3));
                    n = (sel == 0) ? FL : (sel == 1) ? int'($urandom_range(1, FL - 1)) : FL + 20;
                    d = int'($urandom_range(6));
                    repeat (d) begin @(posedge clk_50m); #1; end
                    send_frame(1, n, sel != 2, int'($urandom_range(40)), -1, f1, e1);
                end
            join
        end
        drain();

        check("final_len_err_count", got_len, exp_len);
        check("final_drop_err_count", got_drop, exp_drop);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
